// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// rsa_pkg : shared RSA datapath types and helpers (MMM_FINAL_SUB_EN aware)
// Rev 1.0
// ============================================================================
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CORRECT = 3'd3,
    DONE    = 3'd4
  } mmm_state_e;

  // Edges from the start-sampling edge to the edge after which done is high.
  function automatic int mmm_latency(input int width);
`ifdef MMM_FINAL_SUB_EN
    return width + 3;
`else
    return width + 2;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmm_step.sv
`default_nettype none
// ============================================================================
// mmm_step : one combinational radix-2 Montgomery iteration
// Rev 1.0
// ============================================================================
module mmm_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] acc_i,
  input  logic             a_bit_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH+1:0] acc_o
);

  // One spare bit keeps out-of-contract operands from wrapping silently.
  logic [WIDTH+2:0] sum;
  logic [WIDTH+2:0] t;

  always_comb begin
    sum   = {1'b0, acc_i} + (a_bit_i ? {3'b000, b_i} : '0);
    t     = sum[0] ? (sum + {3'b000, n_i}) : sum;
    acc_o = t[WIDTH+2:1];
  end

endmodule
`default_nettype wire

// File: rtl/mmm_bitserial.sv
`default_nettype none
// ============================================================================
// mmm_bitserial : radix-2 bit-serial Montgomery multiplier, R = A*B*2^-WIDTH mod N
// Optional final subtraction enabled by MMM_FINAL_SUB_EN.  Rev 1.0
// ============================================================================
module mmm_bitserial
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  input  logic             a_bit,
  output logic             sr_ena,
  output logic             sr_load,
  output logic             sr_clear_n,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mmm_state_e       state_q;
  logic [WIDTH+1:0] acc_q;
  logic [WIDTH+1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH:0]   result_q;
  logic             done_q;

  mmm_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .a_bit_i (a_bit),
    .b_i     (b_q),
    .n_i     (n_q),
    .acc_o   (acc_d)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      b_q      <= '0;
      n_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (!ena) begin
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) state_q <= LOAD;
        end
        LOAD: begin
          b_q     <= b;
          n_q     <= n;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
`ifdef MMM_FINAL_SUB_EN
            state_q <= CORRECT;
`else
            state_q <= DONE;
`endif
          end
        end
`ifdef MMM_FINAL_SUB_EN
        CORRECT: begin
          if (acc_q >= {2'b00, n_q}) acc_q <= acc_q - {2'b00, n_q};
          state_q <= DONE;
        end
`endif
        DONE: begin
          result_q <= acc_q[WIDTH:0];
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Upstream shift-register controls follow the state directly so they line up
  // with the edge that acts on them.
  always_comb begin
    sr_ena     = 1'b0;
    sr_load    = 1'b0;
    sr_clear_n = 1'b1;
    if (ena) begin
      case (state_q)
        LOAD: begin
          sr_ena  = 1'b1;
          sr_load = 1'b1;
        end
        RUN: sr_ena = 1'b1;
        DONE: begin
          sr_ena     = 1'b1;
          sr_clear_n = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mmm_bitserial.sv
`default_nettype none
// ============================================================================
// tb_mmm_bitserial : randomized self-checking bench with upstream A shift register
// Rev 1.0
// ============================================================================
module tb_mmm_bitserial;

  localparam int W = 8;
  localparam int L = rsa_pkg::mmm_latency(W);

  logic         clk   = 1'b0;
  logic         rstb  = 1'b0;
  logic         ena   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] n     = '0;
  logic [W-1:0] a_src = '0;
  logic         a_bit;
  logic         sr_ena, sr_load, sr_clear_n, busy, done;
  logic [W:0]   result;
  logic [W-1:0] up_q  = '0;

  int n_checks = 0;
  int n_fail   = 0;

  mmm_bitserial #(.WIDTH(W)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .ena        (ena),
    .start      (start),
    .b          (b),
    .n          (n),
    .a_bit      (a_bit),
    .sr_ena     (sr_ena),
    .sr_load    (sr_load),
    .sr_clear_n (sr_clear_n),
    .result     (result),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Upstream A operand shift register, LSB first.
  always @(posedge clk) begin
    if (sr_ena) begin
      if (!sr_clear_n)  up_q <= '0;
      else if (sr_load) up_q <= a_src;
      else              up_q <= up_q >> 1;
    end
  end
  assign a_bit = up_q[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: A*B*inv(2^W) mod N, inverse found by exhaustive search.
  function automatic int mont_ref(input int av, input int bv, input int nv);
    int inv = 0;
    for (int k = 1; k < nv; k++)
      if (((k << W) % nv) == 1) inv = k;
    return (((av * bv) % nv) * inv) % nv;
  endfunction

  task automatic chk_res(input string tag, input int res, input int av, input int bv, input int nv);
    int exp = mont_ref(av, bv, nv);
`ifdef MMM_FINAL_SUB_EN
    chk(tag, res, exp);
`else
    chk(tag, res, (res == exp + nv) ? exp + nv : exp);
`endif
  endtask

  task automatic run_op(input int av, input int bv, input int nv, input int stall_at,
                        input int pulse_at, output int res, output int lat);
    int eff = 0;
    lat = -1;
    res = 0;
    @(posedge clk); #1;
    a_src = W'(av); b = W'(bv); n = W'(nv); start = 1'b1; ena = 1'b1;
    for (int c = 0; c < 100 && lat < 0; c++) begin
      @(posedge clk); #1;
      start = (c == pulse_at);
      ena   = !(stall_at >= 0 && c >= stall_at && c < stall_at + 3);
      @(negedge clk);
      if (!ena) begin
        chk("stall_sr_ena", sr_ena, 0);
        chk("stall_sr_load", sr_load, 0);
        chk("stall_sr_clear_n", sr_clear_n, 1);
        chk("stall_done", done, 0);
      end else begin
        chk("done", done, eff == L);
        chk("busy", busy, eff < L);
        chk("sr_load", sr_load, eff == 0);
        chk("sr_clear_n", sr_clear_n, eff != L - 1);
        chk("sr_ena", sr_ena, (eff <= W) || (eff == L - 1));
        if (done) begin
          lat = c;
          res = int'(result);
          chk("upstream_zero", up_q, 0);
        end
        eff++;
      end
    end
    if (lat < 0) chk("timeout", lat, L);
    start = 1'b0;
    ena   = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("result_hold", result, res);
    end
  endtask

  int da[3] = '{7, 12, 0};
  int db[3] = '{5, 12, 9};
  int dx[3] = '{1, 3, 0};

  initial begin
    int res, lat, av, bv, nv;
    rstb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sr_ena", sr_ena, 0);
    chk("rst_sr_load", sr_load, 0);
    chk("rst_sr_clear_n", sr_clear_n, 1);
    @(posedge clk); #1 rstb = 1'b1;

    for (int i = 0; i < 3; i++) begin
      run_op(da[i], db[i], 13, -1, -1, res, lat);
      chk("directed_result", res, dx[i]);
      chk("directed_latency", lat, L);
    end

    run_op(7, 5, 13, 4, -1, res, lat);
    chk("stall_result", res, 1);
    chk("stall_latency", lat, L + 3);

    run_op(7, 5, 13, -1, 4, res, lat);
    chk("busy_start_result", res, 1);
    chk("busy_start_latency", lat, L);

    run_op(12, 12, 13, -1, L - 1, res, lat);
    chk("done_start_result", res, 3);

    // Synchronous reset in the middle of RUN.
    @(posedge clk); #1;
    a_src = 8'd7; b = 8'd5; n = 8'd13; start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 3) rstb = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1 rstb = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sr_ena", sr_ena, 0);
    run_op(7, 5, 13, -1, -1, res, lat);
    chk("after_rst_result", res, 1);

    for (int i = 0; i < 1000; i++) begin
      nv = 2 * $urandom_range(1, 127) + 1;
      bv = $urandom_range(0, nv - 1);
      av = $urandom_range(0, 255);
      run_op(av, bv, nv, -1, -1, res, lat);
      chk_res("rand_result", res, av, bv, nv);
      chk("rand_latency", lat, L);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
